// File: rtl/mrsc_stream_encoder.sv
// Streaming MRSC encoder: buffers multi-lane beats in a FIFO and serializes them
// as one 32-bit codeword per cycle, tagged with lane index and last-of-beat flag.

// Combinational MRSC encoder. The 16 data bits form a 4x4 matrix d[r][c] = data[4r+c];
// codeword = {data, row parity, column parity, diagonal parity, anti-diagonal parity}.
module mrsc_encoder (
  input  logic [15:0] data,
  output logic [31:0] code
);
  logic [3:0] row_p;
  logic [3:0] col_p;
  logic [3:0] diag_p;
  logic [3:0] adiag_p;

  // diag_p[k] covers cells with (c - r) mod 4 == k; adiag_p[k] covers (c + r) mod 4 == k
  for (genvar gi = 0; gi < 4; gi++) begin : g_parity
    assign row_p[gi]   = ^data[4*gi +: 4];
    assign col_p[gi]   = data[gi] ^ data[4+gi] ^ data[8+gi] ^ data[12+gi];
    assign diag_p[gi]  = data[gi%4] ^ data[4+((gi+1)%4)] ^ data[8+((gi+2)%4)] ^ data[12+((gi+3)%4)];
    assign adiag_p[gi] = data[gi%4] ^ data[4+((gi+3)%4)] ^ data[8+((gi+2)%4)] ^ data[12+((gi+1)%4)];
  end

  assign code = {data, row_p, col_p, diag_p, adiag_p};
endmodule

module mrsc_stream_encoder #(
  parameter  int LANES = 4,
  parameter  int DEPTH = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = LANES * 16 + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*16-1:0] in_data,
  input  logic                in_enc_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_word,
  output logic [LW-1:0]       out_lane,
  output logic                out_last,
  output logic [AW:0]         fifo_level,
  output logic [31:0]         word_count
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [BW-1:0] hold_reg;
  logic [LW-1:0] lane_reg, lane_next;
  logic [31:0]   count_reg;
  logic          push, pop, fifo_empty, last_lane, out_fire;
  logic [15:0]   lane_words [LANES];
  logic [15:0]   lane_data;
  logic [31:0]   enc_word;

  assign in_ready   = (level_reg != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level_reg == '0);
  assign last_lane  = (lane_reg == LW'(LANES - 1));
  assign out_fire   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    pop        = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          lane_next  = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!last_lane) begin
            lane_next = lane_reg + 1'b1;
          end else if (!fifo_empty) begin
            // back-to-back pop keeps the output stream free of bubbles
            pop       = 1'b1;
            lane_next = '0;
          end else begin
            lane_next  = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array left unreset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_enc_en, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      hold_reg   <= '0;
      lane_reg   <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        hold_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (out_fire) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_words[gi] = hold_reg[16*gi +: 16];
  end

  assign lane_data = lane_words[lane_reg];

  mrsc_encoder u_enc (
    .data (lane_data),
    .code (enc_word)
  );

  // Top bit of the holding register is the per-beat encode/bypass mode
  assign out_word   = hold_reg[BW-1] ? enc_word : {lane_data, 16'h0000};
  assign out_lane   = lane_reg;
  assign out_last   = out_valid && last_lane;
  assign fifo_level = level_reg;
  assign word_count = count_reg;
endmodule

// File: tb/tb_mrsc_stream_encoder.sv
// Directed bench for mrsc_stream_encoder: table-driven beat vectors with hand-computed
// codewords plus sequences for latency, backpressure, streaming and reset mid-burst.
module tb_mrsc_stream_encoder;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_enc_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [1:0]  out_lane;
  logic        out_last;
  logic [2:0]  fifo_level;
  logic [31:0] word_count;

  mrsc_stream_encoder #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_enc_en  (in_enc_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  typedef struct {
    logic [31:0] word;
    int          lane;
    logic        last;
    longint      t;
  } obs_t;

  typedef struct {
    logic [63:0]       data;
    logic              en;
    logic [3:0][31:0]  w;
  } vec_t;

  obs_t        mon_q[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_q.push_back('{word: out_word, lane: int'(out_lane), last: out_last, t: cyc});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_model(input logic [15:0] d);
    logic [3:0] row, col, dg, ad;
    row = '0; col = '0; dg = '0; ad = '0;
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = i / 4;
      c = i % 4;
      row[r]             ^= d[i];
      col[c]             ^= d[i];
      dg[(c - r + 4) % 4] ^= d[i];
      ad[(c + r) % 4]     ^= d[i];
    end
    return {d, row, col, dg, ad};
  endfunction

  task automatic expect_beat(input logic [63:0] data, input logic en);
    for (int k = 0; k < LANES; k++) begin
      logic [15:0] d;
      d = data[16*k +: 16];
      exp_q.push_back(en ? enc_model(d) : {d, 16'h0000});
    end
  endtask

  task automatic send_beat(input logic [63:0] data, input logic en);
    logic ok;
    int   t;
    t = 0;
    in_valid  = 1'b1;
    in_data   = data;
    in_enc_en = en;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 200 cycles");
    end
  endtask

  // Waits for exp_q.size() words, then compares words, lanes, last flags (and optionally gaps)
  task automatic compare_words(input string name, input bit gap_chk);
    int n, t;
    n = exp_q.size();
    t = 0;
    while (mon_q.size() < n && t < n * 8 + 50) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_count"}, mon_q.size(), n);
    if (mon_q.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_word%0d", name, i), mon_q[i].word, exp_q[i]);
        check($sformatf("%s_lane%0d", name, i), mon_q[i].lane, i % LANES);
        check($sformatf("%s_last%0d", name, i), mon_q[i].last, (i % LANES) == LANES - 1);
        if (gap_chk) check($sformatf("%s_gap%0d", name, i), mon_q[i].t - mon_q[0].t, i);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] bp_data [6];
    logic        bp_en   [6];
    logic        r;
    int          accepted, t;

    vecs[0].data = 64'h0400_00FF_0000_80FA; vecs[0].en = 1'b1;
    vecs[0].w    = {32'h0400_4411, 32'h00FF_0000, 32'h0000_0000, 32'h80FA_8D41};
    vecs[1].data = 64'hFFFF_FFFF_FFFF_FFFF; vecs[1].en = 1'b0;
    vecs[1].w    = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    vecs[2].data = 64'h0400_00FF_0000_80FA; vecs[2].en = 1'b0;
    vecs[2].w    = {32'h0400_0000, 32'h00FF_0000, 32'h0000_0000, 32'h80FA_0000};
    vecs[3].data = 64'h0012_8000_0001_0400; vecs[3].en = 1'b1;
    vecs[3].w    = {32'h0012_33A0, 32'h8000_8814, 32'h0001_1111, 32'h0400_4411};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_enc_en = 1'b0; out_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); in_data = {$urandom, $urandom};
      in_enc_en = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_word", out_word, 0);
      check("rst_out_lane", out_lane, 0);
      check("rst_out_last", out_last, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_word_count", word_count, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);
      check("idle_fifo_level", fifo_level, 0);
    end
    @(posedge clk);
    #1;

    // Single beat with latency check
    in_valid = 1'b1; in_data = vecs[0].data; in_enc_en = 1'b1;
    @(negedge clk);
    check("single_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_n", out_valid, 0);
    check("lat_level_n", fifo_level, 1);
    @(negedge clk);
    check("lat_valid_n1", out_valid, 1);
    check("lat_lane_n1", out_lane, 0);
    check("lat_level_n1", fifo_level, 0);
    for (int k = 0; k < LANES; k++) exp_q.push_back(vecs[0].w[k]);
    compare_words("single", 1'b0);
    check("single_word_count", word_count, 4);

    // Table of hand-computed beats
    for (int v = 0; v < 4; v++) begin
      send_beat(vecs[v].data, vecs[v].en);
      for (int k = 0; k < LANES; k++) exp_q.push_back(vecs[v].w[k]);
      compare_words($sformatf("vec%0d", v), 1'b0);
    end

    // Backpressure: 6 beats offered while out_ready is low
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_data[i] = {$urandom, $urandom};
      bp_en[i]   = 1'($urandom);
      expect_beat(bp_data[i], bp_en[i]);
    end
    accepted = 0;
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1; in_data = bp_data[accepted]; in_enc_en = bp_en[accepted];
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) accepted++;
    end
    check("bp_accepted", accepted, 5);
    in_data = bp_data[5]; in_enc_en = bp_en[5];
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_in_ready_full", in_ready, 0);
      check("bp_level_full", fifo_level, DEPTH);
      check("bp_stall_word", out_word, exp_q[0]);
      check("bp_stall_lane", out_lane, 0);
      check("bp_stall_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 100);
    in_valid = 1'b0;
    check("bp_last_accept", r, 1);
    compare_words("bp", 1'b0);

    // Streaming: 8 random beats back-to-back, no bubbles
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [63:0] d;
      logic        e;
      d = {$urandom, $urandom};
      e = 1'($urandom);
      expect_beat(d, e);
      send_beat(d, e);
    end
    compare_words("stream", 1'b1);
    check("stream_word_count", word_count, 32);

    // Reset mid-burst: two lanes of beat 1 emitted, two beats queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("mid_level", fifo_level, 2);
    out_ready = 1'b1;
    t = 0;
    while (mon_q.size() < 2 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #3;
    rst = 1'b1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_word", out_word, 0);
    check("mid_out_lane", out_lane, 0);
    check("mid_out_last", out_last, 0);
    check("mid_fifo_level", fifo_level, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_word_count", word_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_stale", mon_q.size(), 2);
    mon_q.delete();
    send_beat(vecs[3].data, vecs[3].en);
    for (int k = 0; k < LANES; k++) exp_q.push_back(vecs[3].w[k]);
    compare_words("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
